// File: rtl/regs_file_pkg.sv
// -----------------------------------------------------------------------------
// regs_file_pkg
//   Shared constants and FSM encoding for the integer register file.
//   REG_ADDR_W / REG_DATA_W / REG_NUM : default geometry of the register file.
//   ZERO_REG                          : index of the hardwired-zero register.
//   state_e                           : INIT (clear sweep) / READY (normal use).
// -----------------------------------------------------------------------------
package regs_file_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_NUM    = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/regs_file.sv
// -----------------------------------------------------------------------------
// regs_file
//   Integer register file: one write port (from execute), two combinational
//   read ports (to decode), x0 hardwired to zero. After reset the storage is
//   cleared by a sweep that writes one entry per cycle (entries 1..DEPTH-1),
//   so the array needs only a single write port and maps to RAM-style storage.
//
//   Optional build macro: REGS_WR_BYPASS_EN
//     defined   -> a read of the register being written this cycle returns the
//                  incoming write data (write-to-read forwarding).
//     undefined -> reads return the stored value; new data is visible the
//                  cycle after the write edge.
//
// Ports
//   clk           in   core clock, rising edge
//   rst_n         in   synchronous active-low reset
//   reg_waddr_i   in   write index
//   reg_wdata_i   in   write data
//   reg_wen_i     in   write enable (ignored while the sweep runs)
//   reg1_raddr_i  in   read port 1 index
//   reg1_rdata_o  out  read port 1 data (combinational)
//   reg2_raddr_i  in   read port 2 index
//   reg2_rdata_o  out  read port 2 data (combinational)
//   init_busy_o   out  high during reset and while the clear sweep runs
// -----------------------------------------------------------------------------
module regs_file
  import regs_file_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] reg_waddr_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  input  logic              reg_wen_i,
  input  logic [ADDR_W-1:0] reg1_raddr_i,
  output logic [DATA_W-1:0] reg1_rdata_o,
  input  logic [ADDR_W-1:0] reg2_raddr_i,
  output logic [DATA_W-1:0] reg2_rdata_o,
  output logic              init_busy_o
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Single shared write port: the sweep and functional writes never overlap.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_we  = 1'b0;
    mem_wa  = reg_waddr_i;
    mem_wd  = reg_wdata_i;
    case (state_q)
      ST_INIT: begin
        // Entry 0 is never read, so the sweep starts at 1.
        mem_we = 1'b1;
        mem_wa = ptr_q;
        mem_wd = '0;
        ptr_d  = ptr_q + PTR_FIRST;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (reg_wen_i && (reg_waddr_i != '0)) begin
          mem_we = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= PTR_FIRST;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage has no reset; contents are defined by the sweep.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  // Identical mux for both read ports, in priority order.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] raddr);
    logic [DATA_W-1:0] rdata;
    if (raddr == '0) begin
      rdata = '0;
    end else if (state_q == ST_INIT) begin
      rdata = '0;
`ifdef REGS_WR_BYPASS_EN
    end else if (reg_wen_i && (reg_waddr_i != '0) && (raddr == reg_waddr_i)) begin
      rdata = reg_wdata_i;
`endif
    end else begin
      rdata = mem_q[raddr];
    end
    return rdata;
  endfunction

  assign reg1_rdata_o = read_port(reg1_raddr_i);
  assign reg2_rdata_o = read_port(reg2_raddr_i);

  // Busy is forced during reset itself, before state has been re-initialised.
  assign init_busy_o = ~rst_n | (state_q == ST_INIT);

endmodule

// File: tb/tb_regs_file.sv
// -----------------------------------------------------------------------------
// tb_regs_file
//   Self-checking bench for regs_file: busy-window counting, hand-written
//   corner sequences, a vector table, and randomized traffic against an
//   array-based reference model. Honours REGS_WR_BYPASS_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_regs_file;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef REGS_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] reg_waddr_i;
  logic [DW-1:0] reg_wdata_i;
  logic          reg_wen_i;
  logic [AW-1:0] reg1_raddr_i;
  logic [DW-1:0] reg1_rdata_o;
  logic [AW-1:0] reg2_raddr_i;
  logic [DW-1:0] reg2_rdata_o;
  logic          init_busy_o;

  regs_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_waddr_i  (reg_waddr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_wen_i    (reg_wen_i),
    .reg1_raddr_i (reg1_raddr_i),
    .reg1_rdata_o (reg1_rdata_o),
    .reg2_raddr_i (reg2_raddr_i),
    .reg2_rdata_o (reg2_rdata_o),
    .init_busy_o  (init_busy_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Register contents as the architecture sees them, plus the number of
  // busy cycles still to go in the clear window.
  logic [DW-1:0] m_regs [32];
  int            m_busy_left;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy_left = 31;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else if (m_busy_left > 0) begin
      m_busy_left = m_busy_left - 1;
    end else if (reg_wen_i && reg_waddr_i != 0) begin
      m_regs[reg_waddr_i] = reg_wdata_i;
    end
  end

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0 || m_busy_left > 0) return '0;
    if (BYPASS && reg_wen_i && reg_waddr_i != 0 && a == reg_waddr_i) return reg_wdata_i;
    return m_regs[a];
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    reg_wen_i    = wen;
    reg_waddr_i  = wa;
    reg_wdata_i  = wd;
    reg1_raddr_i = r1;
    reg2_raddr_i = r2;
  endtask

  // Advance one clock; inputs change #1 after the edge, checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles after release and compare against the model each cycle.
  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    while (init_busy_o === 1'b1 && cnt < 100) begin
      #1;
      check({name, "_busy_model"}, {31'd0, init_busy_o}, {31'd0, m_busy_left > 0});
      check({name, "_rd_during_init"}, reg1_rdata_o, '0);
      cnt++;
      tick();
    end
    check({name, "_busy_len"}, DW'(cnt), DW'(31));
  endtask

  task automatic reset_and_sweep(input string name);
    rst_n = 1'b0;
    set_in(1'b0, '0, '0, 5'd3, 5'd31);
    repeat (3) tick();
    #1;
    check({name, "_busy_in_reset"}, {31'd0, init_busy_o}, 32'd1);
    rst_n = 1'b1;
    count_busy(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wen;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  vec_t vecs [8];

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, '0, '0, '0, '0);

    // Post-reset sweep: exactly 31 busy cycles, then all registers zero.
    reset_and_sweep("rst1");
    #1;
    check("busy_low_after_sweep", {31'd0, init_busy_o}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      set_in(1'b0, '0, '0, AW'(i), AW'(32 - i));
      #1;
      check("zero_after_sweep_p1", reg1_rdata_o, '0);
      check("zero_after_sweep_p2", reg2_rdata_o, '0);
      tick();
    end

    vecs[0] = '{1'b1, 5'd5,  32'h1234_5678, 5'd5,  5'd6,  BYPASS ? 32'h1234_5678 : 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd6,  32'h0, 32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0, 32'h1234_5678};
    vecs[4] = '{1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd5,  BYPASS ? 32'hA5A5_A5A5 : 32'h0, 32'h1234_5678};
    vecs[5] = '{1'b0, 5'd7,  32'h0,         5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[6] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 5'd31, 5'd1,  BYPASS ? 32'hDEAD_BEEF : 32'h0, 32'h0};
    vecs[7] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd30, 32'hDEAD_BEEF, 32'h0};

    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].wen, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      #1;
      check($sformatf("vec%0d_p1", i), reg1_rdata_o, vecs[i].e1);
      check($sformatf("vec%0d_p2", i), reg2_rdata_o, vecs[i].e2);
      tick();
    end
    // x0 write left all other registers untouched.
    set_in(1'b0, '0, '0, 5'd6, 5'd1);
    #1;
    check("x0_write_no_side_p1", reg1_rdata_o, '0);
    check("x0_write_no_side_p2", reg2_rdata_o, '0);

    // Write attempted during the sweep (cycle 10) is dropped.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    set_in(1'b0, '0, '0, 5'd3, 5'd3);
    repeat (9) tick();
    set_in(1'b1, 5'd3, 32'h55, 5'd3, 5'd3);
    #1;
    check("init_write_rd", reg1_rdata_o, '0);
    tick();
    set_in(1'b0, '0, '0, 5'd3, 5'd3);
    repeat (40) tick();
    check("init_write_dropped", reg1_rdata_o, '0);
    check("init_write_model", reg2_rdata_o, m_read(5'd3));

    // Write x9 in READY, then reset twice with the second pulse mid-sweep.
    set_in(1'b1, 5'd9, 32'h99, 5'd9, 5'd9);
    tick();
    set_in(1'b0, '0, '0, 5'd9, 5'd9);
    #1;
    check("x9_written", reg1_rdata_o, 32'h99);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_busy("rst_mid");
    #1;
    check("x9_cleared_p1", reg1_rdata_o, '0);
    check("x9_cleared_p2", reg2_rdata_o, '0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom(),
             AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) reg2_raddr_i = reg_waddr_i;
      #1;
      check("rand_p1", reg1_rdata_o, m_read(reg1_raddr_i));
      check("rand_p2", reg2_rdata_o, m_read(reg2_raddr_i));
      check("rand_busy", {31'd0, init_busy_o}, 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
